// File: rtl/dbnc_pkg.sv
// Shared types and default constants for the multi-channel debouncer.
package dbnc_pkg;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} dbnc_state_t;

  localparam int DBNC_TICK_DIV_DEF     = 1000000;
  localparam int DBNC_STABLE_TICKS_DEF = 2;

endpackage

// File: rtl/dbnc_channel.sv
// One debounce channel: input synchroniser, tick-paced stability FSM, edge pulses.
// Optional abort counter enabled by DBNC_GLITCH_CNT_EN.
module dbnc_channel
  import dbnc_pkg::*;
#(
  parameter int STABLE_TICKS = DBNC_STABLE_TICKS_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall
`ifdef DBNC_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CNTW = $clog2(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  dbnc_state_t            state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  // A level reverting to the old value always beats a completing tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
        end else if (tick) begin
          if (cnt_q == CNTW'(STABLE_TICKS - 1)) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
        end else if (tick) begin
          if (cnt_q == CNTW'(STABLE_TICKS - 1)) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = ZERO;
    endcase
    dout_d = (state_d == ONE) || (state_d == WAIT0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= ZERO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DBNC_GLITCH_CNT_EN
  logic       abort;
  logic [7:0] glitch_q, glitch_d;

  assign abort = ((state_q == WAIT1) && !s) || ((state_q == WAIT0) && s);

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) glitch_q <= '0;
    else          glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/multi_debounce_tickgen.sv
// N-channel switch debouncer sharing one programmable tick prescaler.
// Define DBNC_GLITCH_CNT_EN to add the per-channel glitch_cnt output.
module multi_debounce_tickgen
  import dbnc_pkg::*;
#(
  parameter int CH           = 4,
  parameter int TICK_DIV     = DBNC_TICK_DIV_DEF,
  parameter int STABLE_TICKS = DBNC_STABLE_TICKS_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [CH-1:0]   din,
  output logic [CH-1:0]   dout,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic            tick
`ifdef DBNC_GLITCH_CNT_EN
  ,
  output logic [CH*8-1:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick_q is high exactly while the count sits at TICK_DIV-1.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CW'(TICK_DIV - 1)) cnt_d = '0;
      else                            cnt_d = cnt_q + CW'(1);
      tick_d = (cnt_d == CW'(TICK_DIV - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    dbnc_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick_q),
      .din       (din[i]),
      .dout      (dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
`ifdef DBNC_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt[8*i +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_multi_debounce_tickgen.sv
// Self-checking bench for multi_debounce_tickgen: randomized stimulus against a behavioural model.
// Covers glitch_cnt too when DBNC_GLITCH_CNT_EN is defined.
module tb_multi_debounce_tickgen;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [CH-1:0] din = '0;
  logic [CH-1:0] dout, rise, fall;
  logic          tick;
`ifdef DBNC_GLITCH_CNT_EN
  logic [CH*8-1:0] glitch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_debounce_tickgen #(
    .CH(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .tick(tick)
`ifdef DBNC_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  // Reference model: a channel's level follows the synchronised input once the
  // input has differed from it for ST shared ticks; reverting cancels the attempt.
  logic [CH-1:0] m_dout, m_rise, m_fall, m_s;
  logic [CH-1:0] hist [SS];
  logic          m_tick, m_tk;
  bit            m_pend [CH];
  int            m_cnt [CH];
  int            m_glitch [CH];
  int            m_run;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dout = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_run = 0;
      for (int k = 0; k < SS; k++) hist[k] = '0;
      for (int c = 0; c < CH; c++) begin
        m_pend[c] = 0; m_cnt[c] = 0; m_glitch[c] = 0;
      end
    end else begin
      m_s = hist[SS-1];
      m_tk = m_tick;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_s[c] != m_dout[c]) begin
          if (!m_pend[c]) begin
            m_pend[c] = 1; m_cnt[c] = 0;
          end else if (m_tk) begin
            m_cnt[c]++;
            if (m_cnt[c] == ST) begin
              m_pend[c] = 0;
              m_dout[c] = m_s[c];
              if (m_s[c]) m_rise[c] = 1'b1;
              else        m_fall[c] = 1'b1;
            end
          end
        end else if (m_pend[c]) begin
          m_pend[c] = 0;
          if (m_glitch[c] < 255) m_glitch[c]++;
        end
      end
      for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
      if (enable) m_run = (m_run + 1) % TD;
      else        m_run = 0;
      m_tick = enable && (m_run == TD - 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; din = '0; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dout, rise, fall, tick} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b required 0", {dout, rise, fall, tick});
    end
    #2 reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      n_tests++;
      if (tick !== ((n % TD) == TD - 1)) begin
        n_fail++;
        $display("[TB] FAIL reset_tick_phase edge %0d: got %b required %b", n, tick, (n % TD) == TD - 1);
      end
      n_tests++;
      if ({dout, rise, fall} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle edge %0d: got %b required 0", n, {dout, rise, fall});
      end
    end
  endtask

  task automatic test_glitch();
    int hold;
    bit saw;
    hold = $urandom_range(1, 7);
    saw = 0;
    din[0] = 1'b1;
    for (int n = 0; n < hold + 20; n++) begin
      if (n == hold) din[0] = 1'b0;
      step();
      if (dout[0] || rise[0]) saw = 1;
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL glitch_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
    n_tests++;
    if (saw) begin
      n_fail++;
      $display("[TB] FAIL glitch_no_rise hold=%0d: got dout/rise activity required none", hold);
    end
`ifdef DBNC_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt[7:0] !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL glitch_cnt0: got %0d required 1", glitch_cnt[7:0]);
    end
`endif
  endtask

  task automatic test_rise();
    int first, pulses;
    first = -1; pulses = 0;
    repeat ($urandom_range(0, 3)) step();
    din[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (rise[0]) pulses++;
      if (dout[0] && first < 0) begin
        first = n;
        n_tests++;
        if (rise[0] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL rise_coincident: got %b required 1", rise[0]);
        end
      end
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL rise_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
      n_tests++;
      if ({dout[1], rise[1], fall[1]} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL rise_ch1_quiet n=%0d: got %b required 000", n, {dout[1], rise[1], fall[1]});
      end
    end
    n_tests++;
    if (first < 10 || first > 15 || pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL rise_latency: got edge %0d pulses %0d required 10..15 and 1", first, pulses);
    end
  endtask

  task automatic test_fall();
    int low, pulses, zero_at;
    bit lost;
    low = $urandom_range(1, 7);
    lost = 0; pulses = 0; zero_at = -1;
    din[0] = 1'b0;
    for (int n = 0; n < low + 20; n++) begin
      if (n == low) din[0] = 1'b1;
      step();
      if (!dout[0] || fall[0]) lost = 1;
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL fall_abort_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
    n_tests++;
    if (lost) begin
      n_fail++;
      $display("[TB] FAIL fall_abort low=%0d: got dout drop/fall required dout held 1", low);
    end
    din[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (fall[0]) pulses++;
      if (!dout[0] && zero_at < 0) zero_at = n;
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL fall_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
    n_tests++;
    if (pulses != 1 || zero_at < 10 || zero_at > 15) begin
      n_fail++;
      $display("[TB] FAIL fall_pulse: got pulses %0d at edge %0d required 1 within 10..15", pulses, zero_at);
    end
  endtask

  task automatic test_enable();
    bit bad;
    int seen;
    bad = 0; seen = -1;
    din[1] = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (tick || dout[1]) bad = 1;
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL enable_hold_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL enable_hold: got tick or dout[1] high required both 0");
    end
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (dout[1] && seen < 0) seen = n;
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("[TB] FAIL enable_resume_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
    n_tests++;
    if (seen < 0 || seen > 12) begin
      n_fail++;
      $display("[TB] FAIL enable_resume: got dout[1] at edge %0d required 1..12", seen);
    end
  endtask

  task automatic test_random_soak();
    int left [CH];
    for (int c = 0; c < CH; c++) left[c] = $urandom_range(1, 16);
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        left[c]--;
        if (left[c] == 0) begin
          din[c] = ~din[c];
          left[c] = $urandom_range(1, 16);
        end
      end
      step();
      n_tests++;
      if ({dout, rise, fall, tick} !== {m_dout, m_rise, m_fall, m_tick} || (rise & fall) !== '0) begin
        n_fail++;
        $display("[TB] FAIL soak_model n=%0d: got %b required %b", n, {dout, rise, fall, tick}, {m_dout, m_rise, m_fall, m_tick});
      end
    end
`ifdef DBNC_GLITCH_CNT_EN
    for (int c = 0; c < CH; c++) begin
      n_tests++;
      if (glitch_cnt[8*c +: 8] !== 8'(m_glitch[c])) begin
        n_fail++;
        $display("[TB] FAIL soak_glitch_cnt ch%0d: got %0d required %0d", c, glitch_cnt[8*c +: 8], m_glitch[c]);
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    din = '1;
    while (dout !== '1 && waited < 40) begin
      step();
      waited++;
    end
    n_tests++;
    if (dout !== '1) begin
      n_fail++;
      $display("[TB] FAIL areset_setup: got dout %b required 11", dout);
    end
    din[0] = 1'b0;
    repeat (4) step();
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({dout, rise, fall, tick} !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_immediate: got %b required 0", {dout, rise, fall, tick});
    end
`ifdef DBNC_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_glitch_cnt: got %h required 0", glitch_cnt);
    end
`endif
    din = '0;
    repeat (2) step();
    #2 reset_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_tests++;
      if (tick !== ((n % TD) == TD - 1) || {dout, rise, fall} !== '0) begin
        n_fail++;
        $display("[TB] FAIL areset_restart edge %0d: got tick %b outs %b required %b and 0", n, tick, {dout, rise, fall}, (n % TD) == TD - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_fall();
    test_enable();
    test_random_soak();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
